apb_master_mc: RTL

Parametrised, multi-slave successor to the processor-to-APB master bridge. Accepts single read/write commands from the processor bus and runs them as APB SETUP/ACCESS transfers to one of `NUM_SLAVES` slaves. Adds generic address/data widths, per-slave ready/rdata/error routing, a wait-state timeout, PSLVERR reporting and back-to-back transfers. Sits between the processor bus and the APB slave fabric.

---
 rtl/apb_master_mc.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/apb_master_mc.sv
// rtl/apb_master_mc.sv - multi-slave processor-to-APB master bridge with wait-state timeout
module apb_master_mc #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int NUM_SLAVES = 2,
    parameter int TIMEOUT    = 16,
    localparam int SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         p_start,
    input  logic                         p_write,
    input  logic [ADDR_W-1:0]            p_addr,
    input  logic [DATA_W-1:0]            p_wdata,
    input  logic [SEL_W-1:0]             p_sel,
    output logic [DATA_W-1:0]            p_rdata,
    output logic                         p_stable,
    output logic                         p_error,
    output logic                         p_busy,
    output logic [NUM_SLAVES-1:0]        a_sel,
    output logic                         a_enable,
    output logic                         a_write,
    output logic [ADDR_W-1:0]            a_addr,
    output logic [DATA_W-1:0]            a_wdata,
    input  logic [NUM_SLAVES-1:0]        a_ready,
    input  logic [NUM_SLAVES*DATA_W-1:0] a_rdata,
    input  logic [NUM_SLAVES-1:0]        a_slverr
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]       p_rdata_q, p_rdata_d;
    logic                    p_stable_q, p_stable_d;
    logic                    p_error_q, p_error_d;
    logic                    p_busy_q, p_busy_d;
    logic [NUM_SLAVES-1:0]   a_sel_q, a_sel_d;
    logic                    a_enable_q, a_enable_d;
    logic                    a_write_q, a_write_d;
    logic [ADDR_W-1:0]       a_addr_q, a_addr_d;
    logic [DATA_W-1:0]       a_wdata_q, a_wdata_d;

    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_W-1:0]       sel_rdata;
    logic [NUM_SLAVES-1:0]   start_onehot;
    logic                    start_valid;

    // Only the addressed slave's response lines are observed.
    always_comb begin
        sel_ready    = 1'b0;
        sel_err      = 1'b0;
        sel_rdata    = '0;
        start_onehot = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_q == SEL_W'(k)) begin
                sel_ready = a_ready[k];
                sel_err   = a_slverr[k];
                sel_rdata = a_rdata[k*DATA_W +: DATA_W];
            end
            start_onehot[k] = (p_sel == SEL_W'(k));
        end
        start_valid = (32'(p_sel) < NUM_SLAVES);
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        a_write_d  = a_write_q;
        a_addr_d   = a_addr_q;
        a_wdata_d  = a_wdata_q;
        p_rdata_d  = '0;
        p_stable_d = 1'b0;
        p_error_d  = 1'b0;
        p_busy_d   = 1'b0;
        a_sel_d    = '0;
        a_enable_d = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (p_start) begin
                    sel_d = p_sel;
                    if (start_valid) begin
                        state_d   = S_SETUP;
                        cnt_d     = '0;
                        a_write_d = p_write;
                        a_addr_d  = p_addr;
                        a_wdata_d = p_wdata;
                        a_sel_d   = start_onehot;
                        p_busy_d  = 1'b1;
                    end else begin
                        // Out-of-range index completes with an error and never touches the bus.
                        state_d    = S_DONE;
                        p_stable_d = 1'b1;
                        p_error_d  = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                state_d    = S_ACCESS;
                a_sel_d    = a_sel_q;
                a_enable_d = 1'b1;
                p_busy_d   = 1'b1;
            end
            S_ACCESS: begin
                if (sel_ready) begin
                    state_d    = S_DONE;
                    p_stable_d = 1'b1;
                    p_error_d  = sel_err;
                    p_rdata_d  = a_write_q ? '0 : sel_rdata;
                end else if (TIMEOUT > 0 && cnt_q == CNT_MAX) begin
                    state_d    = S_DONE;
                    p_stable_d = 1'b1;
                    p_error_d  = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    a_sel_d    = a_sel_q;
                    a_enable_d = 1'b1;
                    p_busy_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            p_rdata_q  <= '0;
            p_stable_q <= 1'b0;
            p_error_q  <= 1'b0;
            p_busy_q   <= 1'b0;
            a_sel_q    <= '0;
            a_enable_q <= 1'b0;
            a_write_q  <= 1'b0;
            a_addr_q   <= '0;
            a_wdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            p_rdata_q  <= p_rdata_d;
            p_stable_q <= p_stable_d;
            p_error_q  <= p_error_d;
            p_busy_q   <= p_busy_d;
            a_sel_q    <= a_sel_d;
            a_enable_q <= a_enable_d;
            a_write_q  <= a_write_d;
            a_addr_q   <= a_addr_d;
            a_wdata_q  <= a_wdata_d;
        end
    end

    assign p_rdata  = p_rdata_q;
    assign p_stable = p_stable_q;
    assign p_error  = p_error_q;
    assign p_busy   = p_busy_q;
    assign a_sel    = a_sel_q;
    assign a_enable = a_enable_q;
    assign a_write  = a_write_q;
    assign a_addr   = a_addr_q;
    assign a_wdata  = a_wdata_q;

endmodule
